truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequential stimulus-and-capture stage for the 4-input combinational exercise circuits. It drives A, B, C, D through all 16 combinations in ascending order (A = MSB, D = LSB) and holds each vector for a settle interval. It samples the circuit output F back into a 16-bit truth-table register and reports completion with a start/busy/done handshake. It sits directly upstream of the combinational block (feeding its inputs) and consumes that block's output.

Parameters:
SETTLE, 2, number of cycles each vector is held before F is sampled; legal range 1..15; 0 is illegal.
N_IN, 4, number of circuit inputs; fixed at 4 for this revision; the table width is 2**N_IN = 16.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
abort  input  1  terminate the sweep; the block returns to IDLE with no done pulse
f_in  input  1  F output of the combinational block under test
a_out  output  1  stimulus A (vector bit 3)
b_out  output  1  stimulus B (vector bit 2)
c_out  output  1  stimulus C (vector bit 1)
d_out  output  1  stimulus D (vector bit 0)
busy  output  1  high in DRIVE and SAMPLE
done  output  1  one-cycle pulse after the 16th sample
table_out  output  16  captured truth table; bit i = F for vector i
ones_count  output  5  number of 1s captured in the current or last sweep (0..16)

Behaviour:
- Reset (async, active-high): state IDLE; index=0; settle counter=0; a/b/c/d_out=0; busy=0; done=0; table_out=16'h0000; ones_count=0.
- Outputs are registered; {a_out,b_out,c_out,d_out} = index[3:0] in DRIVE and SAMPLE, and 4'b0000 in IDLE and DONE.
- IDLE: start=1 at an edge moves the block to DRIVE. In the same edge: index=0, table_out=0, ones_count=0, settle counter=0.
- DRIVE: the settle counter increments each cycle. When the counter reaches SETTLE-1, the block moves to SAMPLE on the next edge.
- SAMPLE (one cycle): at the edge leaving SAMPLE, table_out[index] is set to f_in and ones_count is incremented by f_in.
  - If index==15, the block moves to DONE.
  - Otherwise index increments, the settle counter clears, and the block moves to DRIVE.
- DONE (one cycle): done=1, busy=0. The block moves to IDLE on the next edge. start is ignored during DONE.
- Latency: 16*(SETTLE+1) cycles from the start edge to the edge that sets DONE. With SETTLE=2 that is 48 cycles, and done is seen on the following cycle.
- start while busy: ignored, with no restart.
- abort:
  - Has priority over all transitions in DRIVE and SAMPLE.
  - Next state is IDLE; vector outputs go to 0; table_out and ones_count hold their partial values; no done pulse.
  - abort in IDLE or DONE has no effect.
- start and abort high together in IDLE: abort wins and the block stays in IDLE.
- table_out and ones_count are stable from the DONE cycle until the next accepted start.
- Reset asserted mid-sweep: all registers clear immediately. There is no done pulse and no partial table is retained.
- index wrap: index never advances beyond 15; no modulo wrap occurs.
- ones_count is 5 bits so that it holds 16 without overflow.

Decomposition:
- Shared package truth_sweep_pkg holds:
  - the state encoding IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3;
  - the constants N_VEC=16 and IDX_W=4.
- One natural sub-module, settle_timer, provides the clearable up-counter with a terminal-count flag at SETTLE-1, parameterised by SETTLE.
- The FSM, index register, and capture logic stay in the top module.

Test Plan:
- Reset then idle: hold Reset for 3 cycles, then release with start=0. Required: all outputs 0 and busy=0 for 10 cycles.
- Full sweep against the XOR/OR/AND exercise circuit F=(A^~B... corrected: F=(A xor B)&(C|~D)), with SETTLE=2 and a 1-cycle start pulse. Required: done is seen 48 cycles later, table_out=16'h0DD0, ones_count=6, and the vectors appear in order 0..15 each held for 3 cycles.
- Constant inputs: f_in tied to 1, full sweep. Required: table_out=16'hFFFF and ones_count=16. f_in tied to 0: table_out=16'h0000 and ones_count=0.
- start during a sweep: pulse start at vector 5. Required: no restart, and done arrives at the same cycle as an undisturbed sweep.
- abort mid-sweep: with f_in=1, assert abort while index=7 in DRIVE. Required: IDLE next cycle, outputs 0, no done pulse, table_out=16'h007F, ones_count=7. A following start clears the table and completes normally.
- Async reset in SAMPLE of vector 10. Required: all outputs 0 without waiting for a clock edge and no done pulse. Also rerun with SETTLE=1, where the required latency is 32 cycles.

Source files
------------

// File: rtl/truth_sweep_pkg.sv
// ============================================================================
// truth_sweep_pkg : shared state encoding and sizing for the truth-table sweeper
// Revision 1.0
// ============================================================================
`default_nettype none

package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  localparam int N_VEC = 16;
  localparam int IDX_W = 4;

endpackage

`default_nettype wire

// File: rtl/settle_timer.sv
// ============================================================================
// settle_timer : clearable up-counter flagging terminal count at SETTLE-1
// Revision 1.0
// ============================================================================
`default_nettype none

module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == 4'(SETTLE - 1));

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper : drives all 16 input vectors and captures F per vector
// Revision 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int N_IN   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   f_i,
  output logic                   a_o,
  output logic                   b_o,
  output logic                   c_o,
  output logic                   d_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [(2**N_IN)-1:0]   table_o,
  output logic [IDX_W:0]         ones_count_o
);

  sweep_state_e          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [(2**N_IN)-1:0]  table_q, table_d;
  logic [IDX_W:0]        ones_q, ones_d;
  logic [IDX_W-1:0]      vec_q, vec_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  settle_tc;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != DRIVE),
    .en_i  (state_q == DRIVE),
    .tc_o  (settle_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d = DRIVE;
          idx_d   = '0;
          table_d = '0;
          ones_d  = '0;
        end
      end
      DRIVE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (settle_tc) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        // abort pre-empts the capture, so the aborted vector is never recorded
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          table_d[idx_q] = f_i;
          ones_d         = ones_q + {{IDX_W{1'b0}}, f_i};
          if (idx_q == IDX_W'(N_VEC - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DRIVE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    vec_d  = busy_d ? idx_d : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_o          = vec_q[3];
  assign b_o          = vec_q[2];
  assign c_o          = vec_q[1];
  assign d_o          = vec_q[0];
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign table_o      = table_q;
  assign ones_count_o = ones_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// tb_truth_table_sweeper : randomized self-checking bench against a table model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

  logic        clk;
  logic        rst;
  logic        start, abort, start1;
  logic        a, b, c, d, busy, done;
  logic        a1, b1, c1, d1, busy1, done1;
  logic [15:0] tbl, tbl1;
  logic [4:0]  ones, ones1;
  logic        f2, f1;
  logic [3:0]  vec, vec1;
  int          mode;
  logic [15:0] rand_tt;
  int          total;
  int          bad;

  // Circuit under test as seen by the sweeper: 0 = exercise circuit, 1/2 = constants, else random table
  function automatic logic circ(input int md, input logic [15:0] tt, input logic [3:0] v);
    case (md)
      0:       return (v[3] ^ v[2]) & (v[1] | ~v[0]);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return tt[v];
    endcase
  endfunction

  assign vec  = {a, b, c, d};
  assign vec1 = {a1, b1, c1, d1};
  assign f2   = circ(mode, rand_tt, vec);
  assign f1   = circ(mode, rand_tt, vec1);

  truth_table_sweeper #(.SETTLE(2), .N_IN(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .f_i(f2),
    .a_o(a), .b_o(b), .c_o(c), .d_o(d), .busy_o(busy), .done_o(done),
    .table_o(tbl), .ones_count_o(ones)
  );

  truth_table_sweeper #(.SETTLE(1), .N_IN(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .abort_i(1'b0), .f_i(f1),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .busy_o(busy1), .done_o(done1),
    .table_o(tbl1), .ones_count_o(ones1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_table(input int md, input logic [15:0] tt);
    logic [15:0] t;
    t = '0;
    for (int v = 0; v < 16; v++) t[v] = circ(md, tt, 4'(v));
    return t;
  endfunction

  function automatic logic [4:0] popcnt(input logic [15:0] t);
    logic [4:0] n;
    n = '0;
    for (int v = 0; v < 16; v++) n += {4'd0, t[v]};
    return n;
  endfunction

  // Full sweep on the SETTLE=2 instance; optional extra start pulse at a given vector
  task automatic run_sweep(input int md, input int extra_start_vec, input string tag);
    int k, nbad, nbusy, done_k;
    logic [15:0] et;
    mode   = md;
    et     = model_table(md, rand_tt);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    k = 0; nbad = 0; nbusy = 0; done_k = -1;
    while (k < 120 && done_k < 0) begin
      if (done) begin
        done_k = k;
      end else begin
        if (busy) begin
          nbusy++;
          if (vec != 4'(k / 3)) nbad++;
        end
        start = (extra_start_vec >= 0 && k == extra_start_vec * 3);
        tick();
        k++;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(done_k), 32'd48);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd48);
    chk({tag, "_vec_order_errs"}, 32'(nbad), 32'd0);
    chk({tag, "_table"}, {16'd0, tbl}, {16'd0, et});
    chk({tag, "_ones"}, {27'd0, ones}, {27'd0, popcnt(et)});
    tick();
    chk({tag, "_after_done"}, {27'd0, done, busy, vec}, 32'd0);
    chk({tag, "_table_hold"}, {16'd0, tbl}, {16'd0, et});
  endtask

  // Abort at vector j, phase p (0..1 DRIVE, 2 SAMPLE) with f tied high
  task automatic run_abort(input int j, input int p, input string tag);
    int ndone;
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (j * 3 + p) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk({tag, "_outs"}, {27'd0, done, busy, vec}, 32'd0);
    chk({tag, "_table"}, {16'd0, tbl}, 32'((1 << j) - 1));
    chk({tag, "_ones"}, {27'd0, ones}, 32'(j));
    ndone = 0;
    repeat (60) begin
      tick();
      if (done || busy) ndone++;
    end
    chk({tag, "_stays_idle"}, 32'(ndone), 32'd0);
  endtask

  initial begin
    int k, done_k, ndone, j, p;
    logic [15:0] et;
    total = 0; bad = 0;
    start = 1'b0; abort = 1'b0; start1 = 1'b0;
    mode = 0; rand_tt = 16'h0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_idle", {3'd0, done, busy, vec, tbl, ones}, 32'd0);
    end

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {30'd0, busy, done}, 32'd0);

    run_sweep(0, -1, "xor_circ");
    chk("xor_circ_known", {16'd0, tbl}, 32'h0DD0);
    run_sweep(1, -1, "f_one");
    chk("f_one_known", {16'd0, tbl}, 32'hFFFF);
    run_sweep(2, -1, "f_zero");
    run_sweep(0, 5, "start_busy");
    for (int r = 0; r < 3; r++) begin
      rand_tt = 16'($urandom);
      run_sweep(3, int'($urandom_range(0, 15)), "rand_sweep");
    end

    run_abort(7, 0, "abort_v7");
    rand_tt = 16'($urandom);
    run_sweep(3, -1, "post_abort");
    j = int'($urandom_range(1, 14));
    p = int'($urandom_range(0, 2));
    run_abort(j, p, "abort_rand");

    // Async reset while vector 10 is in SAMPLE
    rand_tt = 16'($urandom);
    mode  = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10 * 3 + 2) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", {3'd0, done, busy, vec, tbl, ones}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ndone = 0;
    repeat (60) begin
      tick();
      if (done) ndone++;
    end
    chk("async_rst_no_done", 32'(ndone), 32'd0);
    chk("async_rst_table", {16'd0, tbl}, 32'd0);

    // SETTLE=1 instance
    rand_tt = 16'($urandom);
    mode   = 3;
    et     = model_table(3, rand_tt);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    k = 0; done_k = -1; ndone = 0;
    while (k < 100 && done_k < 0) begin
      if (done1) begin
        done_k = k;
      end else begin
        if (busy1 && vec1 != 4'(k / 2)) ndone++;
        tick();
        k++;
      end
    end
    chk("s1_latency", 32'(done_k), 32'd32);
    chk("s1_vec_order_errs", 32'(ndone), 32'd0);
    chk("s1_table", {16'd0, tbl1}, {16'd0, et});
    chk("s1_ones", {27'd0, ones1}, {27'd0, popcnt(et)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
